ram2_ctrl: RTL

CPU-side bus master for the external RAM2 asynchronous SRAM. Accepts instruction-fetch requests from the IF stage and load/store requests from the MEM stage, arbitrates between them on the single SRAM port, and sequences the active-low SRAM control strobes. Returns fetched instructions and load data, and raises a pipeline stall while any request is outstanding. Replaces direct wiring of the pipeline to the combinational RAM2 model.

---
 rtl/ram2_ctrl_pkg.sv | 34 +++
 rtl/ram2_fetch_buf.sv | 56 +++++
 rtl/ram2_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ram2_ctrl_pkg.sv
// Shared definitions for the RAM2 SRAM bus master.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state encoding, SRAM address width, CPU address width,
//           active-low strobe levels for the SRAM control pins.
package ram2_ctrl_pkg;

  localparam int RAM2_ADDR_W = 18;
  localparam int CPU_ADDR_W  = 16;

  // SRAM control pins are active-low; named levels keep the FSM output
  // decode readable.
  localparam logic RamChipEnable   = 1'b0;
  localparam logic RamChipDisable  = 1'b1;
  localparam logic RamOutEnable    = 1'b0;
  localparam logic RamOutDisable   = 1'b1;
  localparam logic RamWriteEnable  = 1'b0;
  localparam logic RamWriteDisable = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETUP  = 3'd1,
    ST_RD_SAMPLE = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_PULSE  = 3'd4,
    ST_WR_HOLD   = 3'd5
  } state_e;

  // A data request needs the chip enable plus at least one select.
  function automatic logic data_req(input logic ce, input logic re, input logic we);
    return ce & (re | we);
  endfunction

endpackage

// File: rtl/ram2_fetch_buf.sv
// One-entry instruction buffer {valid, tag, inst} in front of the SRAM fetch path.
// Latency: hit is combinational from lookup_addr; fill/invalidate take effect next cycle.
// Backpressure: none; the controller decides when a lookup is used.
// Ports: clk/rst (sync, active-high); lookup_addr -> hit, hit_inst;
//        fill_en/fill_tag/fill_inst load the entry; inval clears valid.
module ram2_fetch_buf
  import ram2_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CPU_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     hit_inst,
  input  logic                  fill_en,
  input  logic [CPU_ADDR_W-1:0] fill_tag,
  input  logic [DATA_W-1:0]     fill_inst,
  input  logic                  inval
);

  logic                  valid_q, valid_d;
  logic [CPU_ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0]     inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    inst_d  = inst_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      inst_d  = fill_inst;
    end
    // A store may target the buffered word, so any accepted write drops it.
    if (inval) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      inst_q  <= inst_d;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_inst = inst_q;

endmodule

// File: rtl/ram2_ctrl.sv
// CPU-side bus master for the RAM2 async SRAM: arbitrates IF fetches and MEM loads/stores.
// Latency: read done 2 cycles after acceptance, write done 3 cycles; buffered fetch hit 1 cycle.
// Backpressure: requesters hold their level until done; stall_req is high while any is pending.
// Ports: clk, rst (sync, active-high); if_req/if_addr -> if_inst/if_done;
//        mem_ce/mem_re/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_done; stall_req;
//        ram_addr, ram_data (tristate), ram_ce_n/ram_oe_n/ram_we_n (active-low).
// Option: define RAM2_FETCH_BUF_EN to add the one-entry fetch buffer (ram2_fetch_buf).
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM2_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [CPU_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]     if_inst,
  output logic                  if_done,
  input  logic                  mem_ce,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_done,
  output logic                  stall_req,
  output logic [ADDR_W-1:0]     ram_addr,
  inout  wire  [DATA_W-1:0]     ram_data,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  state_e              state_q, state_d;
  logic                src_data_q, src_data_d;  // active access belongs to MEM, not IF
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_inst_q, if_inst_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;

  logic                dreq;
  logic                in_idle;
  logic                fetch_pend;
  logic                fetch_go;
  logic                hit_go;
  logic [DATA_W-1:0]   hit_inst;
  logic                drive_en;

  assign dreq    = data_req(mem_ce, mem_re, mem_we);
  assign in_idle = (state_q == ST_IDLE);

  // During a buffered-hit completion the FSM sits in IDLE while if_req is
  // still high; masking with if_done_q keeps that cycle from re-issuing it.
  assign fetch_pend = if_req & ~if_done_q;

`ifdef RAM2_FETCH_BUF_EN
  logic buf_hit;

  ram2_fetch_buf #(
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (if_addr),
    .hit         (buf_hit),
    .hit_inst    (hit_inst),
    .fill_en     ((state_q == ST_RD_SETUP) && !src_data_q),
    .fill_tag    (addr_q[CPU_ADDR_W-1:0]),
    .fill_inst   (ram_data),
    .inval       (in_idle && dreq && mem_we)
  );

  assign hit_go = in_idle & ~dreq & fetch_pend & buf_hit;
`else
  assign hit_go   = 1'b0;
  assign hit_inst = '0;
`endif

  // Data requests win arbitration; a fetch only starts an SRAM read on a miss.
  assign fetch_go = in_idle & ~dreq & fetch_pend & ~hit_go;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dreq) begin
          // Both selects high resolves to a write.
          state_d = mem_we ? ST_WR_SETUP : ST_RD_SETUP;
        end else if (fetch_go) begin
          state_d = ST_RD_SETUP;
        end
      end
      ST_RD_SETUP:  state_d = ST_RD_SAMPLE;
      ST_RD_SAMPLE: state_d = ST_IDLE;
      ST_WR_SETUP:  state_d = ST_WR_PULSE;
      ST_WR_PULSE:  state_d = ST_WR_HOLD;
      ST_WR_HOLD:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so a reset that lands
  // mid-write releases we_n and the data bus right after that edge.
  always_comb begin
    ram_ce_n = RamChipDisable;
    ram_oe_n = RamOutDisable;
    ram_we_n = RamWriteDisable;
    drive_en = 1'b0;
    unique case (state_q)
      ST_RD_SETUP, ST_RD_SAMPLE: begin
        ram_ce_n = RamChipEnable;
        ram_oe_n = RamOutEnable;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ram_ce_n = RamChipEnable;
        drive_en = 1'b1;
      end
      ST_WR_PULSE: begin
        ram_ce_n = RamChipEnable;
        ram_we_n = RamWriteEnable;
        drive_en = 1'b1;
      end
      default: begin
        ram_ce_n = RamChipDisable;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    src_data_d  = src_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    // Address and store data are captured on acceptance so the requester's
    // inputs may wander for the rest of the access.
    if (in_idle && dreq) begin
      src_data_d = 1'b1;
      addr_d     = ADDR_W'(mem_addr);
      if (mem_we) begin
        wdata_d = mem_wdata;
      end
    end else if (fetch_go) begin
      src_data_d = 1'b0;
      addr_d     = ADDR_W'(if_addr);
    end

    // The SRAM has had the whole setup cycle to drive the bus; capture at its end.
    if (state_q == ST_RD_SETUP) begin
      if (src_data_q) begin
        mem_rdata_d = ram_data;
        mem_done_d  = 1'b1;
      end else begin
        if_inst_d = ram_data;
        if_done_d = 1'b1;
      end
    end

    if (state_q == ST_WR_PULSE) begin
      mem_done_d = 1'b1;
    end

    if (hit_go) begin
      if_inst_d = hit_inst;
      if_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_data_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      src_data_q  <= src_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign if_inst   = if_inst_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign stall_req = (if_req & ~if_done_q) | (dreq & ~mem_done_q);

endmodule
